// File: rtl/u_hz_pkg.sv
// Shared constants, types and helpers for the u_hz_seq hazard controller.
package u_hz_pkg;

  localparam int unsigned STG_IFU = 0;
  localparam int unsigned STG_EX0 = 1;
  localparam int unsigned STG_EX1 = 2;
  localparam int unsigned STG_EX2 = 3;

  // Tracker entries carry the widest supported register index; narrower REGW is zero-extended.
  localparam int unsigned REGW_MAX = 8;

  typedef struct packed {
    logic                vld;
    logic [REGW_MAX-1:0] rd;
  } ld_ent_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/u_hz_ldtrk.sv
// In-flight load tracker: LDLAT-deep shift register of {vld, rd} plus the load-use comparator.
module u_hz_ldtrk
  import u_hz_pkg::*;
#(
  parameter int unsigned REGW  = 5,
  parameter int unsigned LDLAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            wr_vld,
  input  logic [REGW-1:0] wr_rd,
  input  logic [REGW-1:0] ex0_rs1,
  input  logic [REGW-1:0] ex0_rs2,
  input  logic [1:0]      ex0_rs_vld,
  output logic            luh
);

  ld_ent_t trk_q [LDLAT];
  ld_ent_t trk_d [LDLAT];

  always_comb begin
    trk_d = trk_q;
    if (!hold) begin
      // x0 is hard-wired zero, so a load to it can never create a dependency.
      trk_d[0].vld = wr_vld & (wr_rd != '0);
      trk_d[0].rd  = REGW_MAX'(wr_rd);
      for (int i = 1; i < int'(LDLAT); i++) begin
        trk_d[i] = trk_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LDLAT); i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      trk_q <= trk_d;
    end
  end

  always_comb begin
    luh = 1'b0;
    for (int i = 0; i < int'(LDLAT); i++) begin
      if (trk_q[i].vld && (trk_q[i].rd != '0)) begin
        if (ex0_rs_vld[0] && (trk_q[i].rd == REGW_MAX'(ex0_rs1))) luh = 1'b1;
        if (ex0_rs_vld[1] && (trk_q[i].rd == REGW_MAX'(ex0_rs2))) luh = 1'b1;
      end
    end
  end

endmodule

// File: rtl/u_hz_seq.sv
// Stateful pipeline hazard controller: load-use stalls, multi-cycle execute stalls, branch flushes.
// Optional saturating stall/flush statistics counters are enabled by defining HZ_STAT_EN.
module u_hz_seq
  import u_hz_pkg::*;
#(
  parameter int unsigned NSTG  = 4,
  parameter int unsigned REGW  = 5,
  parameter int unsigned LDLAT = 2,
  parameter int unsigned BRFL  = 1,
  parameter int unsigned MCW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_vld,
  input  logic            branch,
  input  logic [REGW-1:0] ex0_rs1,
  input  logic [REGW-1:0] ex0_rs2,
  input  logic [1:0]      ex0_rs_vld,
  input  logic            ld_issue,
  input  logic [REGW-1:0] ld_rd,
  input  logic            mc_start,
  input  logic [MCW-1:0]  mc_lat,
  output logic [NSTG-1:0] hzf,
  output logic [NSTG-1:0] hzs,
  output logic            mc_busy,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  logic [MCW-1:0] mc_cnt_q, mc_cnt_d;
  logic           mc_long;
  logic           luh;
  logic           br_take;
  logic           ld_wr;

  // A start is only seen while the counter is idle; L of 0 or 1 completes without stalling.
  assign mc_long = rst_n & mc_start & (mc_cnt_q == '0) & (mc_lat >= MCW'(2));
  assign mc_busy = rst_n & (mc_long | (mc_cnt_q != '0));

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (mc_long) begin
      mc_cnt_d = mc_lat - MCW'(1);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_q <= '0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    hzf     = '0;
    hzs     = '0;
    br_take = 1'b0;
    if (!rst_n) begin
      hzf = '1;
    end else if (mc_busy) begin
      hzs[STG_IFU] = 1'b1;
      hzs[STG_EX0] = 1'b1;
      hzs[STG_EX1] = 1'b1;
      hzf[STG_EX2] = 1'b1;
    end else if (branch) begin
      br_take = 1'b1;
      for (int i = 0; i <= int'(BRFL); i++) begin
        hzf[i] = 1'b1;
      end
    end else if (luh) begin
      hzs[STG_IFU] = 1'b1;
      hzs[STG_EX0] = 1'b1;
      hzf[STG_EX1] = 1'b1;
    end else if (!ifu_vld) begin
      hzf[STG_EX0] = 1'b1;
    end
  end

  // A load stalled or squashed in ex0 is recorded only once it actually leaves ex0.
  assign ld_wr = ld_issue & ~hzs[STG_EX0] & ~hzf[STG_EX0];

  u_hz_ldtrk #(
    .REGW  (REGW),
    .LDLAT (LDLAT)
  ) u_ldtrk (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (mc_busy),
    .wr_vld     (ld_wr),
    .wr_rd      (ld_rd),
    .ex0_rs1    (ex0_rs1),
    .ex0_rs2    (ex0_rs2),
    .ex0_rs_vld (ex0_rs_vld),
    .luh        (luh)
  );

`ifdef HZ_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|hzs)   stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (br_take) flush_cnt_q <= sat_inc32(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_br_take;
  assign unused_br_take = br_take;
  assign stall_cnt      = '0;
  assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_u_hz_seq.sv
// Directed, table-driven bench for u_hz_seq (default parameters), plus multi-cycle sequences.
module tb_u_hz_seq;

  logic        clk;
  logic        rst_n;
  logic        ifu_vld;
  logic        branch;
  logic [4:0]  ex0_rs1;
  logic [4:0]  ex0_rs2;
  logic [1:0]  ex0_rs_vld;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        mc_start;
  logic [4:0]  mc_lat;
  logic [3:0]  hzf;
  logic [3:0]  hzs;
  logic        mc_busy;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  u_hz_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ifu_vld    (ifu_vld),
    .branch     (branch),
    .ex0_rs1    (ex0_rs1),
    .ex0_rs2    (ex0_rs2),
    .ex0_rs_vld (ex0_rs_vld),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .mc_start   (mc_start),
    .mc_lat     (mc_lat),
    .hzf        (hzf),
    .hzs        (hzs),
    .mc_busy    (mc_busy),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ifu_vld;
    logic       branch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] rs_vld;
    logic       ld_issue;
    logic [4:0] ld_rd;
    logic       mc_start;
    logic [4:0] mc_lat;
    logic [3:0] hzf;
    logic [3:0] hzs;
    logic       busy;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  function automatic vec_t mk(input logic iv, input logic br, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [1:0] rv, input logic ld,
                              input logic [4:0] lr, input logic ms, input logic [4:0] ml,
                              input logic [3:0] f, input logic [3:0] s, input logic b);
    vec_t v;
    v.ifu_vld = iv; v.branch = br; v.rs1 = r1; v.rs2 = r2; v.rs_vld = rv;
    v.ld_issue = ld; v.ld_rd = lr; v.mc_start = ms; v.mc_lat = ml;
    v.hzf = f; v.hzs = s; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic exp_out(input string nm, input logic [3:0] f, input logic [3:0] s,
                         input logic b);
    chk({nm, ".hzf"}, 32'(hzf), 32'(f));
    chk({nm, ".hzs"}, 32'(hzs), 32'(s));
    chk({nm, ".busy"}, 32'(mc_busy), 32'(b));
  endtask

  task automatic drv(input logic iv, input logic br, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [1:0] rv, input logic ld, input logic [4:0] lr,
                     input logic ms, input logic [4:0] ml);
    ifu_vld = iv; branch = br; ex0_rs1 = r1; ex0_rs2 = r2; ex0_rs_vld = rv;
    ld_issue = ld; ld_rd = lr; mc_start = ms; mc_lat = ml;
  endtask

  task automatic idle();
    drv(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Cycle step: new inputs in the low phase, sample 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Stateless / short-memory vectors, starting from a clean state.
    vt[0]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[1]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010, 4'b0000, 0);
    vt[2]  = mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0011, 4'b0000, 0);
    vt[3]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0011, 4'b0000, 0);
    vt[4]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
    vt[5]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b0010, 4'b0000, 0);
    vt[6]  = mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[7]  = mk(1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[8]  = mk(1, 0, 0, 0, 2'b00, 1, 7, 0, 0, 4'b0000, 4'b0000, 0);
    vt[9]  = mk(1, 0, 7, 7, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[10] = mk(1, 0, 0, 7, 2'b10, 0, 0, 0, 0, 4'b0100, 4'b0011, 0);
    vt[11] = mk(1, 0, 0, 7, 2'b10, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vt[12] = mk(1, 1, 0, 0, 2'b00, 1, 3, 0, 0, 4'b0011, 4'b0000, 0);
    vt[13] = mk(1, 0, 3, 0, 2'b01, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);

    rst_n = 1'b0;
    idle();
    #1;
    exp_out("reset", 4'b1111, 4'b0000, 1'b0);
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.flush_cnt", flush_cnt, 32'd0);
    mc_start = 1'b1; mc_lat = 5'd4; branch = 1'b1;
    #1;
    exp_out("reset_mcstart", 4'b1111, 4'b0000, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc();
      drv(vt[i].ifu_vld, vt[i].branch, vt[i].rs1, vt[i].rs2, vt[i].rs_vld, vt[i].ld_issue,
          vt[i].ld_rd, vt[i].mc_start, vt[i].mc_lat);
      #1;
      exp_out($sformatf("vec%0d", i), vt[i].hzf, vt[i].hzs, vt[i].busy);
    end

    // Load x5, consumer stalls for LDLAT cycles then clears.
    cyc(); idle(); ld_issue = 1'b1; ld_rd = 5'd5; #1;
    exp_out("ld5_issue", 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); ex0_rs1 = 5'd5; ex0_rs_vld = 2'b01; #1;
      if (i < 2) exp_out($sformatf("ld5_use%0d", i), 4'b0100, 4'b0011, 1'b0);
      else       exp_out("ld5_clear", 4'b0000, 4'b0000, 1'b0);
    end

    // Multi-cycle L=4: four busy cycles, restart and branch ignored while busy.
    cyc(); idle(); mc_start = 1'b1; mc_lat = 5'd4; #1;
    exp_out("mc_c0", 4'b1000, 4'b0111, 1'b1);
    cyc(); idle(); mc_start = 1'b1; mc_lat = 5'd4; #1;
    exp_out("mc_c1_restart", 4'b1000, 4'b0111, 1'b1);
    cyc(); idle(); branch = 1'b1; #1;
    exp_out("mc_c2_branch", 4'b1000, 4'b0111, 1'b1);
    cyc(); idle(); #1;
    exp_out("mc_c3", 4'b1000, 4'b0111, 1'b1);
    cyc(); idle(); #1;
    exp_out("mc_done", 4'b0000, 4'b0000, 1'b0);
    cyc(); idle(); mc_start = 1'b1; mc_lat = 5'd1; #1;
    exp_out("mc_lat1", 4'b0000, 4'b0000, 1'b0);

    // Branch suppresses a pending load-use stall.
    cyc(); idle(); ld_issue = 1'b1; ld_rd = 5'd9; #1;
    exp_out("br_ld9", 4'b0000, 4'b0000, 1'b0);
    cyc(); idle(); ex0_rs1 = 5'd9; ex0_rs_vld = 2'b01; branch = 1'b1; #1;
    exp_out("br_over_luh", 4'b0011, 4'b0000, 1'b0);
    cyc(); idle(); ex0_rs1 = 5'd9; ex0_rs_vld = 2'b01; #1;
    exp_out("luh_after_br", 4'b0100, 4'b0011, 1'b0);
    cyc(); idle(); ex0_rs1 = 5'd9; ex0_rs_vld = 2'b01; #1;
    exp_out("luh_clear", 4'b0000, 4'b0000, 1'b0);

    // Reset asserted mid multi-cycle stall with a load held in the tracker.
    cyc(); idle(); ld_issue = 1'b1; ld_rd = 5'd6; #1;
    exp_out("rst_ld6", 4'b0000, 4'b0000, 1'b0);
    cyc(); idle(); mc_start = 1'b1; mc_lat = 5'd4; #1;
    exp_out("rst_mc0", 4'b1000, 4'b0111, 1'b1);
    cyc(); idle(); #1;
    cyc(); idle(); #1;
    exp_out("rst_mc_cnt2", 4'b1000, 4'b0111, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_out("rst_async", 4'b1111, 4'b0000, 1'b0);
    @(posedge clk);
    cyc(); rst_n = 1'b1; idle(); ex0_rs1 = 5'd6; ex0_rs_vld = 2'b01; #1;
    exp_out("rst_after0", 4'b0000, 4'b0000, 1'b0);
    cyc(); idle(); ex0_rs1 = 5'd6; ex0_rs_vld = 2'b01; #1;
    exp_out("rst_after1", 4'b0000, 4'b0000, 1'b0);

`ifdef HZ_STAT_EN
    do_reset();
    idle(); #1;
    chk("stat_clr.stall", stall_cnt, 32'd0);
    chk("stat_clr.flush", flush_cnt, 32'd0);
    mc_start = 1'b1; mc_lat = 5'd3;
    cyc(); idle();
    cyc(); idle();
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); #1;
    chk("stat.stall_cnt", stall_cnt, 32'd3);
    chk("stat.flush_cnt", flush_cnt, 32'd2);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    force dut.flush_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    mc_start = 1'b1; mc_lat = 5'd3;
    cyc(); idle();
    cyc(); idle();
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); #1;
    chk("sat.stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    chk("sat.flush_cnt", flush_cnt, 32'hFFFF_FFFF);
`else
    do_reset();
    mc_start = 1'b1; mc_lat = 5'd3;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); branch = 1'b1;
    cyc(); idle(); #1;
    chk("nostat.stall_cnt", stall_cnt, 32'd0);
    chk("nostat.flush_cnt", flush_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
